// File: rtl/cipher_seq_ctrl.sv
// Sequencer between the serial input taker and an iterative round-based cipher core:
// gathers one block/key, loads the core, steps it ROUNDS times, and offers the result.
module cipher_seq_ctrl #(
    parameter int ROUNDS  = 32,
    parameter int TIMEOUT = 64,
    parameter int DATA_W  = 32,
    parameter int KEY_W   = 64,
    localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              busy,
    output logic              taker_start,
    input  logic              taker_done,
    input  logic [DATA_W-1:0] taker_data,
    input  logic [KEY_W-1:0]  taker_key,
    output logic              core_load,
    output logic [DATA_W-1:0] core_data,
    output logic [KEY_W-1:0]  core_key,
    output logic              core_round_en,
    output logic [RW-1:0]     core_round,
    input  logic [DATA_W-1:0] core_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              err,
    input  logic              err_clr,
    output logic [15:0]       blk_cnt,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_GATHER = 3'd2,
        S_LOAD   = 3'd3,
        S_RUN    = 3'd4,
        S_CAPT   = 3'd5,
        S_HOLD   = 3'd6
    } state_t;

    localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [RW-1:0] rnd;
    logic          timeout;

    // A late taker_done on the final GATHER cycle still wins over the timeout.
    assign timeout = (state == S_GATHER) && !taker_done && (timer == TMR_LAST);

    assign busy          = (state != S_IDLE);
    assign taker_start   = (state == S_START);
    assign core_load     = (state == S_LOAD);
    assign core_round_en = (state == S_RUN);
    assign core_round    = rnd;
    assign state_dbg     = state;

    // Result handshake: res_data is stable while res_valid is high; the block is
    // delivered on the cycle both res_valid and res_ready are high, never withdrawn.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            rnd       <= '0;
            core_data <= '0;
            core_key  <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            if (timeout)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req)
                        state <= S_START;
                end
                S_START: begin
                    timer <= '0;
                    state <= S_GATHER;
                end
                S_GATHER: begin
                    if (taker_done) begin
                        core_data <= taker_data;
                        core_key  <= taker_key;
                        state     <= S_LOAD;
                    end else if (timer == TMR_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_LOAD: begin
                    rnd   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (rnd == RND_LAST)
                        state <= S_CAPT;
                    else
                        rnd <= rnd + 1'b1;
                end
                S_CAPT: begin
                    res_data  <= core_result;
                    res_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        blk_cnt   <= blk_cnt + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
